// File: rtl/i2c_led_pkg.sv
// Shared types and constants for the I2C-controlled LED register file.
package i2c_led_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } state_t;

   localparam logic [1:0] REG_PATTERN = 2'd0;
   localparam logic [1:0] REG_CTRL    = 2'd1;
   localparam logic [1:0] REG_DIV_LO  = 2'd2;
   localparam logic [1:0] REG_DIV_HI  = 2'd3;

   localparam logic [DATA_W-1:0]   RST_PATTERN = 8'h1E;
   localparam logic [DATA_W-1:0]   RST_CTRL    = 8'h01;
   localparam logic [2*DATA_W-1:0] RST_DIVIDER = 16'h00B7;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one asynchronous bus line, plus a history flop
// for rise/fall detection. Not reset, so a reset never fabricates an edge.
module i2c_sync_edge
   import i2c_led_pkg::*;
(
   input  logic clk,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic meta_p0;
   logic sync_p1;
   logic hist_p2;

   always_ff @(posedge clk) begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      hist_p2 <= sync_p1;
   end

   assign lvl  = sync_p1;
   assign rise = sync_p1 & ~hist_p2;
   assign fall = ~sync_p1 & hist_p2;

endmodule

// File: rtl/i2c_led_regs.sv
// I2C slave holding the LED rotator's pattern, control and divider registers;
// pulses pattern_load whenever the pattern register is written.
module i2c_led_regs
   import i2c_led_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h42
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [7:0]  pattern,
   output logic [7:0]  ctrl,
   output logic [15:0] divider,
   output logic        pattern_load
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_sync_edge u_scl (.clk(clk), .din(scl_in), .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
   i2c_sync_edge u_sda (.clk(clk), .din(sda_in), .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall));

   logic start, stop;
   assign start = sda_fall & scl_lvl;
   assign stop  = sda_rise & scl_lvl;

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic [1:0]  ptr;
   logic        rw_q;
   logic [7:0]  shreg;
   logic [7:0]  byte_in;
   logic        oe_nxt;
   logic        scl_fall_p1;

   assign byte_in = {shreg[6:0], sda_lvl};

   function automatic logic [7:0] rd_mux(input logic [1:0] p);
      case (p)
         REG_PATTERN: rd_mux = pattern;
         REG_CTRL:    rd_mux = ctrl;
         REG_DIV_LO:  rd_mux = divider[7:0];
         default:     rd_mux = divider[15:8];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // START outranks a coincident bit sample
   always_comb begin
      state_nxt = state;
      if (stop)
         state_nxt = ST_IDLE;
      else if (start)
         state_nxt = ST_ADDR;
      else if (scl_rise) begin
         case (state)
            ST_ADDR:     if (cnt == 3'd7)
                            state_nxt = (shreg[6:0] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            ST_ADDR_ACK: state_nxt = rw_q ? ST_RD_DATA : ST_PTR;
            ST_PTR:      if (cnt == 3'd7) state_nxt = ST_PTR_ACK;
            ST_PTR_ACK:  state_nxt = ST_WR_DATA;
            ST_WR_DATA:  if (cnt == 3'd7) state_nxt = ST_WR_ACK;
            ST_WR_ACK:   state_nxt = ST_WR_DATA;
            ST_RD_DATA:  if (cnt == 3'd7) state_nxt = ST_RD_ACK;
            ST_RD_ACK:   state_nxt = sda_lvl ? ST_IGNORE : ST_RD_DATA;
            default:     state_nxt = state;
         endcase
      end
   end

   always_comb begin
      oe_nxt = 1'b0;
      case (state)
         ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: oe_nxt = 1'b1;
         ST_RD_DATA:                         oe_nxt = ~shreg[7];
         default:                            oe_nxt = 1'b0;
      endcase
   end

   // extra stage puts the SDA update a fixed 4 clk after the SCL pin falls
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_fall_p1 <= 1'b0;
         sda_oe      <= 1'b0;
      end else begin
         scl_fall_p1 <= scl_fall;
         if (stop)
            sda_oe <= 1'b0;
         else if (scl_fall_p1)
            sda_oe <= oe_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= 3'd0;
         ptr          <= REG_PATTERN;
         rw_q         <= 1'b0;
         pattern      <= RST_PATTERN;
         ctrl         <= RST_CTRL;
         divider      <= RST_DIVIDER;
         pattern_load <= 1'b0;
      end else begin
         pattern_load <= 1'b0;
         if (start || stop)
            cnt <= 3'd0;
         else if (scl_rise) begin
            case (state)
               ST_ADDR, ST_PTR, ST_WR_DATA, ST_RD_DATA: begin
                  cnt   <= cnt + 3'd1;
                  shreg <= byte_in;
                  if (cnt == 3'd7) begin
                     if (state == ST_ADDR) rw_q <= sda_lvl;
                     if (state == ST_PTR)  ptr  <= byte_in[1:0];
                     if (state == ST_WR_DATA) begin
                        case (ptr)
                           REG_PATTERN: begin
                              pattern      <= byte_in;
                              pattern_load <= 1'b1;
                           end
                           REG_CTRL:    ctrl           <= byte_in;
                           REG_DIV_LO:  divider[7:0]   <= byte_in;
                           default:     divider[15:8]  <= byte_in;
                        endcase
                        ptr <= ptr + 2'd1;
                     end
                  end
               end
               ST_ADDR_ACK: shreg <= rd_mux(ptr);
               ST_RD_ACK: if (!sda_lvl) begin
                  ptr   <= ptr + 2'd1;
                  shreg <= rd_mux(ptr + 2'd1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_led_regs.sv
// Directed bench: an open-drain I2C master drives the register file and
// compares against hand-computed register and ACK values.
`timescale 1ns/1ps
module tb_i2c_led_regs;

   localparam int Q = 30;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl_m, sda_m;
   logic        scl_in, sda_in;
   logic        sda_oe;
   logic [7:0]  pattern, ctrl;
   logic [15:0] divider;
   logic        pattern_load;

   int total = 0;
   int bad   = 0;
   int pl_cnt  = 0;
   int pl_long = 0;
   logic pl_prev = 1'b0;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_led_regs #(.I2C_ADDR(7'h42)) dut (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .pattern(pattern), .ctrl(ctrl), .divider(divider), .pattern_load(pattern_load)
   );

   always @(negedge clk) begin
      if (pattern_load) pl_cnt++;
      if (pattern_load && pl_prev) pl_long++;
      pl_prev = pattern_load;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_q(input int n);
      repeat (n * Q) @(negedge clk);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      sda_m = 1'b0; wait_q(1);
      scl_m = 1'b0; wait_q(1);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      sda_m = 1'b1; wait_q(1);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    wait_q(1);
      scl_m = 1'b1; wait_q(2);
      scl_m = 1'b0; wait_q(1);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      b = sda_in;   wait_q(1);
      scl_m = 1'b0; wait_q(1);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic a;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(a);
      ack = ~a;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(~ack);
   endtask

   initial begin
      logic       ack, nb;
      logic [7:0] rd;
      int         pl0;

      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_pattern", pattern, 8'h1E);
      check("rst_ctrl", ctrl, 8'h01);
      check("rst_divider", divider, 16'h00B7);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_load", pattern_load, 1'b0);

      // single pattern write
      pl0 = pl_cnt;
      i2c_start;
      write_byte(8'h84, ack); check("w1_addr_ack", ack, 1'b1);
      write_byte(8'h00, ack); check("w1_ptr_ack", ack, 1'b1);
      write_byte(8'h15, ack); check("w1_data_ack", ack, 1'b1);
      i2c_stop;
      check("w1_pattern", pattern, 8'h15);
      check("w1_loads", pl_cnt - pl0, 1);
      check("w1_load_width", pl_long, 0);

      // pointer set, repeated start, two-byte read
      i2c_start;
      write_byte(8'h84, ack); check("r_addr_ack", ack, 1'b1);
      write_byte(8'h01, ack); check("r_ptr_ack", ack, 1'b1);
      i2c_start;
      write_byte(8'h85, ack); check("r_raddr_ack", ack, 1'b1);
      read_byte(rd, 1'b1);    check("r_byte0", rd, 8'h01);
      read_byte(rd, 1'b0);    check("r_byte1", rd, 8'hB7);
      check("r_released", sda_oe, 1'b0);
      i2c_stop;
      check("r_ctrl_kept", ctrl, 8'h01);

      // burst write with pointer wrap 3 -> 0
      pl0 = pl_cnt;
      i2c_start;
      write_byte(8'h84, ack); check("b_addr_ack", ack, 1'b1);
      write_byte(8'h02, ack); check("b_ptr_ack", ack, 1'b1);
      write_byte(8'h34, ack); check("b_d0_ack", ack, 1'b1);
      write_byte(8'h12, ack); check("b_d1_ack", ack, 1'b1);
      write_byte(8'hAA, ack); check("b_d2_ack", ack, 1'b1);
      i2c_stop;
      check("b_divider", divider, 16'h1234);
      check("b_pattern", pattern, 8'hAA);
      check("b_ctrl", ctrl, 8'h01);
      check("b_loads", pl_cnt - pl0, 1);

      // foreign address is ignored
      i2c_start;
      write_byte(8'h86, ack); check("x_addr_nack", ack, 1'b0);
      check("x_sda_oe", sda_oe, 1'b0);
      write_byte(8'h00, ack); check("x_ptr_nack", ack, 1'b0);
      write_byte(8'h77, ack); check("x_data_nack", ack, 1'b0);
      i2c_stop;
      check("x_pattern", pattern, 8'hAA);
      check("x_divider", divider, 16'h1234);

      // reset in the middle of a pattern data byte
      pl0 = pl_cnt;
      i2c_start;
      write_byte(8'h84, ack); check("m_addr_ack", ack, 1'b1);
      write_byte(8'h00, ack); check("m_ptr_ack", ack, 1'b1);
      write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("m_sda_oe", sda_oe, 1'b0);
      check("m_pattern", pattern, 8'h1E);
      check("m_ctrl", ctrl, 8'h01);
      check("m_divider", divider, 16'h00B7);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      read_bit(nb); check("m_tail_nack", nb, 1'b1);
      i2c_stop;
      check("m_pattern_after", pattern, 8'h1E);
      check("m_no_load", pl_cnt - pl0, 0);

      // fresh transaction after reset
      pl0 = pl_cnt;
      i2c_start;
      write_byte(8'h84, ack); check("f_addr_ack", ack, 1'b1);
      write_byte(8'h00, ack); check("f_ptr_ack", ack, 1'b1);
      write_byte(8'h5A, ack); check("f_d0_ack", ack, 1'b1);
      write_byte(8'h03, ack); check("f_d1_ack", ack, 1'b1);
      i2c_stop;
      check("f_pattern", pattern, 8'h5A);
      check("f_ctrl", ctrl, 8'h03);
      check("f_loads", pl_cnt - pl0, 1);
      check("f_load_width", pl_long, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
